// File: rtl/linreg_pkg.sv
// Shared types and width helpers for the
// streaming least-squares line fit engine.
package linreg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    CALC,
    DIV,
    DONE
  } state_t;

  function automatic int acc_w(
    input int w,
    input int n
  );
    return w + $clog2(n + 1);
  endfunction

  function automatic int calc_dw(
    input int w,
    input int n,
    input int frac
  );
    return 2 * w + $clog2(n + 1) + frac + 2;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Signed restoring divider: one quotient bit
// per cycle, truncating toward zero.
module seq_div #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [DW-1:0] dvd,
  input  logic signed [DW-1:0] dvs,
  output logic                 done,
  output logic signed [DW-1:0] q
);

  localparam int CW = $clog2(DW + 1);

  logic          run;
  logic [CW-1:0] cnt;
  logic [DW:0]   rem;
  logic [DW-1:0] quo;
  logic [DW-1:0] div;
  logic          neg;
  logic [DW:0]   sh;
  logic [DW:0]   trial;
  logic [DW-1:0] adv;
  logic [DW-1:0] ads;

  assign adv = dvd[DW-1] ? DW'(-dvd) : DW'(dvd);
  assign ads = dvs[DW-1] ? DW'(-dvs) : DW'(dvs);

  assign sh    = {rem[DW-1:0], quo[DW-1]};
  assign trial = sh - {1'b0, div};

  // Magnitudes are divided; the sign is applied last
  assign q = neg ? -$signed(quo) : $signed(quo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run  <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      div  <= '0;
      neg  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        cnt <= '0;
        rem <= '0;
        quo <= adv;
        div <= ads;
        neg <= dvd[DW-1] ^ dvs[DW-1];
      end else if (run) begin
        if (!trial[DW]) begin
          rem <= trial;
          quo <= {quo[DW-2:0], 1'b1};
        end else begin
          rem <= sh;
          quo <= {quo[DW-2:0], 1'b0};
        end
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DW - 1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/linreg_engine.sv
// Accumulates N (x,y) samples, then derives slope
// and intercept through five chained divisions.
module linreg_engine
  import linreg_pkg::*;
#(
  parameter int W    = 20,
  parameter int N    = 150,
  parameter int FRAC = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] b1,
  output logic [W-1:0] b0,
  output logic         busy,
  output logic         err_div0
);

  localparam int SW = acc_w(W, N);
  localparam int PW = SW + W;
  localparam int DW = calc_dw(W, N, FRAC);
  localparam int CW = $clog2(N + 1);

  state_t st, nx;

  logic [CW-1:0]    cnt;
  logic [SW-1:0]    sumx, sumy;
  logic [PW-1:0]    sumxx, sumxy;
  logic [2*W-1:0]   xx, xy;
  logic [2:0]       idx;
  logic             accept, last;

  logic signed [DW-1:0] sx, sy, sxx, sxy, nn;
  logic signed [DW-1:0] ssxy, ssxx, b1r, my;
  logic signed [DW-1:0] ssxx_n, b0_n;
  logic signed [DW-1:0] dvd, dvs, dq;
  logic                 dstart, ddone;

  assign in_ready  = (st == ACCUM);
  assign out_valid = (st == DONE);
  assign busy      = (st != IDLE);

  assign accept = in_ready && in_valid;
  assign last   = accept && (cnt == CW'(N - 1));

  assign xx = (2*W)'(x) * (2*W)'(x);
  assign xy = (2*W)'(x) * (2*W)'(y);

  assign sx  = $signed(DW'(sumx));
  assign sy  = $signed(DW'(sumy));
  assign sxx = $signed(DW'(sumxx));
  assign sxy = $signed(DW'(sumxy));
  assign nn  = DW'(N);

  assign ssxx_n = sxx - dq;
  assign b0_n   = my - dq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= nx;
  end

  always_comb begin
    nx = st;
    unique case (st)
      IDLE:  if (start) nx = ACCUM;
      ACCUM: if (last) nx = CALC;
      CALC:  nx = DIV;
      DIV:   if (ddone && idx == 3'd4) nx = DONE;
      DONE:  if (out_ready) nx = IDLE;
      default: nx = IDLE;
    endcase
  end

  // Each division is launched in the cycle the previous
  // one finishes, forwarding its quotient where needed
  always_comb begin
    dstart = 1'b0;
    dvd    = '0;
    dvs    = nn;
    if (st == CALC) begin
      dstart = 1'b1;
      dvd    = sx * sy;
    end else if (st == DIV && ddone) begin
      case (idx)
        3'd0: begin
          dstart = 1'b1;
          dvd    = sx * sx;
        end
        3'd1: begin
          dstart = 1'b1;
          dvd    = ssxy <<< FRAC;
          dvs    = ssxx_n;
        end
        3'd2: begin
          dstart = 1'b1;
          dvd    = sy;
        end
        3'd3: begin
          dstart = 1'b1;
          dvd    = b1r * sx;
          dvs    = nn <<< FRAC;
        end
        default: ;
      endcase
    end
  end

  seq_div #(
    .DW(DW)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .start(dstart),
    .dvd  (dvd),
    .dvs  (dvs),
    .done (ddone),
    .q    (dq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      sumx     <= '0;
      sumy     <= '0;
      sumxx    <= '0;
      sumxy    <= '0;
      idx      <= '0;
      ssxy     <= '0;
      ssxx     <= '0;
      b1r      <= '0;
      my       <= '0;
      b1       <= '0;
      b0       <= '0;
      err_div0 <= 1'b0;
    end else begin
      if (st == IDLE && start) begin
        cnt   <= '0;
        sumx  <= '0;
        sumy  <= '0;
        sumxx <= '0;
        sumxy <= '0;
      end
      if (accept) begin
        cnt   <= cnt + 1'b1;
        sumx  <= sumx + SW'(x);
        sumy  <= sumy + SW'(y);
        sumxx <= sumxx + PW'(xx);
        sumxy <= sumxy + PW'(xy);
      end
      if (st == CALC) idx <= '0;
      if (st == DIV && ddone) begin
        idx <= idx + 3'd1;
        case (idx)
          3'd0: ssxy <= sxy - dq;
          3'd1: ssxx <= ssxx_n;
          3'd2: b1r  <= (ssxx == '0) ? '0 : dq;
          3'd3: my   <= dq;
          3'd4: begin
            b1       <= b1r[W-1:0];
            b0       <= b0_n[W-1:0];
            err_div0 <= (ssxx == '0);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/linreg_engine.md
LINREG_ENGINE -- requirements
Module: linreg_engine

Interface
REQ-001 The block SHALL have parameter W, default 20, meaning the sample width and the output width in bits.
REQ-002 The block SHALL have parameter N, default 150, meaning the number of samples per fit (N >= 2).
REQ-003 The block SHALL have parameter FRAC, default 10, meaning the number of fraction bits of b1.
REQ-004 The block SHALL have port clk, input, 1 bit: the clock.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a fit when sampled high in IDLE.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), x (input, W) and y (input, W): the unsigned sample stream.
REQ-008 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1): the result handshake.
REQ-009 The block SHALL have port b1, output, W bits: signed slope, two's complement, FRAC fraction bits.
REQ-010 The block SHALL have port b0, output, W bits: signed integer intercept, two's complement.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port err_div0, output, 1 bit: ssxx was zero; valid while out_valid is high.

Function
REQ-013 The FSM SHALL have states IDLE, ACCUM, CALC, DIV, DONE.
REQ-014 Transitions: IDLE->ACCUM on start; ACCUM->CALC when the Nth sample is accepted; CALC->DIV after 1 cycle; DIV->DONE after the 5th division completes; DONE->IDLE on out_valid&&out_ready.
REQ-015 On entry to ACCUM, sumx, sumy, sumxx, sumxy and the sample counter SHALL clear to 0.
REQ-016 in_ready SHALL be high only in ACCUM; a sample is accepted on in_valid&&in_ready, one per cycle maximum.
REQ-017 sumx and sumy SHALL be W+clog2(N+1) bits wide; sumxx and sumxy SHALL be 2W+clog2(N+1) bits wide; no overflow is possible.
REQ-018 All internal arithmetic SHALL use signed width DW = 2W+clog2(N+1)+FRAC+2.
REQ-019 The results SHALL be computed in this order:
- ssxy = sumxy - sumx*sumy/N
- ssxx = sumxx - sumx*sumx/N
- b1 = (ssxy<<FRAC)/ssxx
- b0 = sumy/N - b1*sumx/(N<<FRAC)
REQ-020 The five divisions SHALL be performed sequentially on one shared divider; every division truncates toward zero.
REQ-021 Each division SHALL take exactly DW+1 cycles, so out_valid rises exactly 5*(DW+1)+1 cycles after the last sample is accepted.
REQ-022 If ssxx==0, the outputs SHALL be b1=0, b0=sumy/N and err_div0=1, with the same latency as a normal fit.
REQ-023 b0 and b1 SHALL be the low W bits of their DW-bit results, with no saturation.
REQ-024 out_valid SHALL be high only in DONE; b0, b1 and err_div0 SHALL hold stable until the output handshake completes.
REQ-025 start SHALL be ignored in every state except IDLE; start and a completing output handshake in the same cycle SHALL NOT skip IDLE.

Reset
REQ-026 rst SHALL force, asynchronously and in any state:
- FSM to IDLE
- all accumulators and the counter to 0
- out_valid=0, in_ready=0, busy=0, err_div0=0, b0=0, b1=0
REQ-027 After rst deasserts mid-fit, the block SHALL require a new start; no partial result is ever emitted.

Structure
REQ-028 The state enum, DW computation, and the clog2-based width helper SHALL live in the shared package linreg_pkg.
REQ-029 The divider SHALL be the sub-module seq_div: parameter DW, signed restoring, one quotient bit per cycle, with start/done handshake and sign fix-up on output.

Verification (W=8, N=4, FRAC=4)
REQ-030 x=1,2,3,4 and y=3,5,7,9 -> b1=32 (2.0), b0=1, err_div0=0, with out_valid exactly 5*(DW+1)+1 cycles after the 4th sample.
REQ-031 x=1,2,3,4 and y=9,7,5,3 -> b1=8'hE0 (-2.0), b0=11, err_div0=0.
REQ-032 x=2,2,2,2 and y=1,2,3,4 -> err_div0=1, b1=0, b0=2.
REQ-033 in_valid toggling every other cycle plus out_ready held low 5 cycles in DONE -> identical results, outputs stable while stalled, in_ready=0 outside ACCUM.
REQ-034 rst pulsed after the 2nd sample, then a fresh start with the REQ-030 data -> all outputs 0 during reset, then b1=32, b0=1.
REQ-035 start pulsed during DIV -> ignored, exactly one result is produced, and busy stays high until the output handshake.
